// File: rtl/conv_layer_ctrl_pkg.sv
// Shared definitions for the convolution layer sequencer: state encoding,
// default index/tag width and pass-size helper.
package conv_layer_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  function automatic int calc_total(input int out_ch, input int dim_out);
    return out_ch * dim_out * dim_out;
  endfunction

endpackage

// File: rtl/conv_save_delay.sv
// Stallable 1-bit shift register that tracks start-of-pixel tokens until the
// matching accumulator value is present.
module conv_save_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic shift,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH-1:0] pipe_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_reg <= '0;
    end else if (flush) begin
      pipe_reg <= '0;
    end else if (shift) begin
      pipe_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign dout  = pipe_reg[DEPTH-1];
  assign empty = ~|pipe_reg;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer-level sequencer for one convolution pass; emits one finished pixel per
// valid/ready beat. Define CONV_CTRL_PERF_EN to add cycle_cnt/stall_cnt ports.
module conv_layer_ctrl
  import conv_layer_ctrl_pkg::*;
#(
  parameter int BYTE         = BYTE_W,
  parameter int ACC_W        = 32,
  parameter int CONV_DIM_OUT = 32,
  parameter int CONV_OUT_CH  = 32,
  parameter int MAC_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    iter_rst,
  output logic                    iter_en,
  input  logic                    iter_save,
  input  logic                    iter_fin,
  output logic                    acc_clr,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [BYTE-1:0]         out_ch,
  output logic [15:0]             out_pix
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int          TOTAL    = calc_total(CONV_OUT_CH, CONV_DIM_OUT);
  localparam int          CNT_W    = $clog2(TOTAL + 1) + 1;
  localparam logic [15:0] PIX_LAST = 16'(CONV_DIM_OUT * CONV_DIM_OUT - 1);

  ctrl_state_t      state_reg, state_next;
  logic             armed_reg;
  logic [CNT_W-1:0] save_cnt_reg;
  logic [15:0]      pix_cnt_reg;
  logic [BYTE-1:0]  ch_cnt_reg;

  logic stall, shift, save_in, fin_take, dl_in, dl_out, dl_empty, dl_flush;
  logic emerge, capture;

  assign stall    = out_valid & ~out_ready;
  assign busy     = (state_reg != ST_IDLE);
  assign iter_rst = (state_reg == ST_INIT);
  assign iter_en  = (state_reg == ST_RUN) & ~stall & ~abort;
  assign done     = (state_reg == ST_DONE) & (~out_valid | out_ready) & ~abort;

  // The end of the pass acts like one more start-of-pixel token so the final
  // pixel is captured MAC_LATENCY cycles after iter_fin is taken.
  assign save_in  = iter_save & iter_en;
  assign fin_take = (state_reg == ST_RUN) & iter_fin & ~stall & ~abort;
  assign dl_in    = save_in | fin_take;
  assign shift    = ((state_reg == ST_RUN) | (state_reg == ST_DRAIN)) & ~stall & ~abort;
  assign dl_flush = abort | (state_reg == ST_INIT);
  assign emerge   = dl_out & shift;
  assign capture  = emerge & armed_reg;
  assign acc_clr  = (state_reg == ST_INIT) | capture;

  conv_save_delay #(
    .DEPTH (MAC_LATENCY)
  ) u_save_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (dl_flush),
    .shift   (shift),
    .din     (dl_in),
    .dout    (dl_out),
    .empty   (dl_empty)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_INIT;
      ST_INIT:  state_next = ST_RUN;
      ST_RUN:   if (iter_fin && !stall) state_next = ST_DRAIN;
      ST_DRAIN: if (dl_empty) state_next = ST_DONE;
      ST_DONE:  if (!out_valid || out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      armed_reg    <= 1'b0;
      save_cnt_reg <= '0;
      err          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_pix      <= '0;
      pix_cnt_reg  <= '0;
      ch_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_INIT) begin
        armed_reg    <= 1'b0;
        save_cnt_reg <= '0;
        err          <= 1'b0;
        pix_cnt_reg  <= '0;
        ch_cnt_reg   <= '0;
      end else begin
        if (save_in) save_cnt_reg <= save_cnt_reg + 1'b1;
        // Full pass delivers TOTAL saves (first only arms) plus the fin token.
        if (fin_take && (save_cnt_reg < CNT_W'(TOTAL))) err <= 1'b1;
        if (emerge) armed_reg <= 1'b1;
        if (capture) begin
          out_data <= acc_in;
          out_ch   <= ch_cnt_reg;
          out_pix  <= pix_cnt_reg;
          if (pix_cnt_reg == PIX_LAST) begin
            pix_cnt_reg <= '0;
            ch_cnt_reg  <= ch_cnt_reg + 1'b1;
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
          end
        end
      end
      if (abort)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

`ifdef CONV_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (state_reg == ST_INIT) begin
      cycle_cnt <= 32'd1;
      stall_cnt <= '0;
    end else begin
      if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
      if ((state_reg == ST_RUN || state_reg == ST_DRAIN) && stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl with a behavioural iterator/MAC model and
// an expected-pixel scoreboard; perf counters checked when CONV_CTRL_PERF_EN is set.
module tb_conv_layer_ctrl;

  localparam int ACC_W = 32;
  localparam int DIM   = 2;
  localparam int OCH   = 2;
  localparam int LAT   = 2;
  localparam int K     = 3;
  localparam int NPIX  = OCH * DIM * DIM;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic iter_save = 1'b0;
  logic iter_fin = 1'b0;
  logic out_ready = 1'b0;
  logic [ACC_W-1:0] acc_in = '0;
  logic busy, done, err, iter_rst, iter_en, acc_clr, out_valid;
  logic [ACC_W-1:0] out_data;
  logic [7:0] out_ch;
  logic [15:0] out_pix;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  conv_layer_ctrl #(
    .BYTE(8), .ACC_W(ACC_W), .CONV_DIM_OUT(DIM), .CONV_OUT_CH(OCH), .MAC_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .iter_rst(iter_rst), .iter_en(iter_en),
    .iter_save(iter_save), .iter_fin(iter_fin), .acc_clr(acc_clr), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_pix(out_pix)
`ifdef CONV_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  ch;
    logic [15:0] pix;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int beats, done_cnt, busy_cyc, stall_cyc, base_cyc;
  int ready_mode;
  bit m_active, m_fin;
  int m_pix, m_elem, m_limit;
  logic [31:0] m_sig;
  logic [31:0] m_hist [LAT];

  function automatic logic [31:0] pix_value(input int p);
    if (p % 2 == 1) return 32'(-(p * 37 + 5));
    return 32'(p * 1000 + 11);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample/check at negedge, advance the iterator/MAC model, drive after posedge.
  task automatic cycle();
    logic en_s, rst_s;
    exp_t e;
    @(negedge clk);
    en_s  = iter_en;
    rst_s = iter_rst;
    if (busy) busy_cyc++;
    if (busy && out_valid && !out_ready) stall_cyc++;
    if (done) done_cnt++;
    if (out_valid && !out_ready) check("iter_en_in_stall", 64'(iter_en), 64'd0);
    if (out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("beat_data", 64'(out_data), 64'(e.data));
        check("beat_ch", 64'(out_ch), 64'(e.ch));
        check("beat_pix", 64'(out_pix), 64'(e.pix));
        $display("[TB] beat %0d data=%0d ch=%0d pix=%0d", beats, $signed(out_data), out_ch, out_pix);
      end
    end
    for (int i = LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_sig;
    if (rst_s) begin
      m_active = 1'b1; m_fin = 1'b0; m_pix = 0; m_elem = 0;
    end else if (m_active && en_s && !m_fin) begin
      if (m_elem == K - 1) begin
        m_elem = 0;
        m_sig  = pix_value(m_pix);
        e.data = pix_value(m_pix);
        e.ch   = 8'(m_pix / (DIM * DIM));
        e.pix  = 16'(m_pix % (DIM * DIM));
        sb.push_back(e);
        if (m_pix == m_limit - 1) m_fin = 1'b1;
        else m_pix++;
      end else begin
        m_elem++;
      end
    end
    @(posedge clk);
    #1;
    iter_save = m_active && !m_fin && (m_elem == 0);
    iter_fin  = m_active && m_fin;
    acc_in    = m_hist[LAT-1];
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
  endtask

  task automatic begin_pass(input int limit);
    m_limit = limit;
    sb.delete();
    beats = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input int n_exp, input logic err_exp);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      cycle();
      n++;
    end
    check({tag, "_no_timeout"}, 64'(done_cnt), 64'd1);
    repeat (4) cycle();
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_beats"}, 64'(beats), 64'(n_exp));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_err"}, 64'(err), 64'(err_exp));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    $display("[TB] pass %s: beats=%0d done=%0d err=%0b busy_cycles=%0d", tag, beats, done_cnt, err, busy_cyc);
  endtask

  initial begin
    int n;
    m_active = 1'b0; m_fin = 1'b0; m_pix = 0; m_elem = 0; m_limit = NPIX;
    m_sig = '0;
    for (int i = 0; i < LAT; i++) m_hist[i] = '0;
    ready_mode = 1;
    beats = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0; base_cyc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_iter_rst", 64'(iter_rst), 64'd0);
    check("rst_iter_en", 64'(iter_en), 64'd0);
    check("rst_acc_clr", 64'(acc_clr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tags", {32'(out_ch), 32'(out_pix)}, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle();

    // 1: reset asserted mid-RUN
    begin_pass(NPIX);
    repeat (6) cycle();
    check("t1_running", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_iter_en", 64'(iter_en), 64'd0);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_strobes", {32'(acc_clr), 32'(iter_rst)}, 64'd0);
    check("t1_done_err", {32'(done), 32'(err)}, 64'd0);
    m_active = 1'b0; m_fin = 1'b0; sb.delete();
    iter_save = 1'b0; iter_fin = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) cycle();
    check("t1_idle_after", 64'(busy), 64'd0);

    // 2: full pass, consumer always ready
    ready_mode = 1;
    begin_pass(NPIX);
    finish_pass("t2", NPIX, 1'b0);
    base_cyc = busy_cyc;

    // 3: consumer ready toggling every cycle
    ready_mode = 2;
    begin_pass(NPIX);
    finish_pass("t3", NPIX, 1'b0);

    // 4: premature iter_fin after 3 saves, then err cleared by the next start
    ready_mode = 1;
    begin_pass(3);
    finish_pass("t4", 3, 1'b1);
    begin_pass(NPIX);
    repeat (2) cycle();
    check("t4_err_cleared", 64'(err), 64'd0);
    finish_pass("t4b", NPIX, 1'b0);

    // 5: abort in DRAIN while the final pixel is valid and unaccepted
    ready_mode = 1;
    begin_pass(NPIX);
    n = 0;
    while (!iter_fin && n < 500) begin cycle(); n++; end
    check("t5_fin_seen", 64'(iter_fin), 64'd1);
    ready_mode = 0;
    cycle();
    n = 0;
    while (!out_valid && n < 50) begin cycle(); n++; end
    check("t5_valid_in_drain", {32'(out_valid), 32'(busy)}, {32'd1, 32'd1});
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    repeat (3) cycle();
    check("t5_no_done", 64'(done_cnt), 64'd0);
    sb.delete();

`ifdef CONV_CTRL_PERF_EN
    // 6: one 5-cycle stall on the first beat
    ready_mode = 1;
    begin_pass(NPIX);
    n = 0;
    while (!out_valid && n < 100) begin cycle(); n++; end
    out_ready = 1'b0;
    ready_mode = 0;
    repeat (4) cycle();
    ready_mode = 1;
    cycle();
    finish_pass("t6", NPIX, 1'b0);
    check("t6_stall_cnt", 64'(stall_cnt), 64'd5);
    check("t6_cycle_cnt", 64'(cycle_cnt), 64'(base_cyc + 5));
    check("t6_cycle_busy", 64'(cycle_cnt), 64'(busy_cyc));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
